// File: rtl/if_pc_redirect_pkg.sv
// Shared types and constants for the IF-stage PC redirect unit.
package if_pc_redirect_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PEND = 2'd1,
        S_HALT = 2'd2
    } pc_state_t;

    localparam int PC_SIZE_DEF = 32;
    localparam int PC_STEP_DEF = 4;

    // Instruction fetch is word aligned: the low ALIGN_BITS of any PC are zero.
    localparam int                       ALIGN_BITS = 2;
    localparam logic [PC_SIZE_DEF-1:0]   ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_pc_adder.sv
// Sequential-fetch adder: next_pc = pc + PC_STEP, wrapping modulo 2^PC_SIZE.
module if_pc_adder
    import if_pc_redirect_pkg::*;
#(
    parameter int PC_SIZE = PC_SIZE_DEF,
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic [PC_SIZE-1:0] pc,
    output logic [PC_SIZE-1:0] next_pc
);

    assign next_pc = pc + PC_SIZE'(PC_STEP);

endmodule

// File: rtl/if_pc_redirect.sv
// IF-stage PC unit: sequential fetch, stall-deferred redirects, IF/ID flush and HALT freeze.
// Optional build macro IF_PC_DELAY_SLOT_EN: branch-delay-slot mode, o_flush tied low.
module if_pc_redirect
    import if_pc_redirect_pkg::*;
#(
    parameter int                 PC_SIZE  = PC_SIZE_DEF,
    parameter int                 PC_STEP  = PC_STEP_DEF,
    parameter logic [PC_SIZE-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_stall,
    input  logic               i_jump_valid,
    input  logic [PC_SIZE-1:0] i_jump_addr,
    input  logic               i_halt,
    output logic [PC_SIZE-1:0] o_pc,
    output logic [PC_SIZE-1:0] o_next_pc,
    output logic               o_flush,
    output logic               o_halted
);

`ifdef IF_PC_DELAY_SLOT_EN
    localparam logic FLUSH_ON = 1'b0;
`else
    localparam logic FLUSH_ON = 1'b1;
`endif

    pc_state_t          state_r, state_next_s;
    logic [PC_SIZE-1:0] pc_r, pc_next_s;
    logic [PC_SIZE-1:0] pend_addr_r, pend_next_s;
    logic               flush_r, flush_next_s;
    logic               halted_r, halted_next_s;
    logic [PC_SIZE-1:0] inc_pc_s;
    logic [PC_SIZE-1:0] target_s;

    if_pc_adder #(
        .PC_SIZE (PC_SIZE),
        .PC_STEP (PC_STEP)
    ) u_adder (
        .pc      (pc_r),
        .next_pc (inc_pc_s)
    );

    assign target_s = {i_jump_addr[PC_SIZE-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};

    // Next-state selection; a disabled cycle holds everything and drops the flush pulse.
    always_comb begin
        state_next_s  = state_r;
        pc_next_s     = pc_r;
        pend_next_s   = pend_addr_r;
        flush_next_s  = 1'b0;
        halted_next_s = halted_r;
        if (!i_enable) begin
            flush_next_s = 1'b0;
        end else begin
            case (state_r)
                S_RUN: begin
                    if (i_jump_valid && !i_stall) begin
                        // A HALT seen alongside a redirect is on the wrong path.
                        pc_next_s    = target_s;
                        flush_next_s = FLUSH_ON;
                    end else if (i_jump_valid) begin
                        pend_next_s  = target_s;
                        state_next_s = S_PEND;
                    end else if (i_stall) begin
                        pc_next_s = pc_r;
                    end else if (i_halt) begin
                        halted_next_s = 1'b1;
                        state_next_s  = S_HALT;
                    end else begin
                        pc_next_s = inc_pc_s;
                    end
                end
                S_PEND: begin
                    if (i_stall) begin
                        if (i_jump_valid) begin
                            pend_next_s = target_s;
                        end else begin
                            pend_next_s = pend_addr_r;
                        end
                    end else begin
                        pc_next_s    = i_jump_valid ? target_s : pend_addr_r;
                        flush_next_s = FLUSH_ON;
                        state_next_s = S_RUN;
                    end
                end
                S_HALT: begin
                    halted_next_s = 1'b1;
                end
                default: begin
                    state_next_s = S_RUN;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r     <= S_RUN;
            pc_r        <= RESET_PC;
            pend_addr_r <= '0;
            flush_r     <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pc_r        <= pc_next_s;
            pend_addr_r <= pend_next_s;
            flush_r     <= flush_next_s;
            halted_r    <= halted_next_s;
        end
    end

    assign o_pc      = pc_r;
    assign o_next_pc = inc_pc_s;
    assign o_flush   = flush_r;
    assign o_halted  = halted_r;

endmodule

// File: doc/if_pc_redirect.md
Name: if_pc_redirect

Overview:
- IF-stage program-counter unit; consumes the registered jump target produced by the ID stage and redirects instruction fetch.
- Holds the architectural fetch PC and advances it by PC_STEP each cycle.
- Captures redirects that arrive during a hazard stall and applies them once the stall clears.
- Flushes the wrong-path instruction in IF/ID and freezes permanently on HALT.

Parameters:
- PC_SIZE, 32, fetch address width in bits.
- PC_STEP, 4, byte increment per sequential fetch.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- i_clock  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  debug-unit run/step enable; low freezes all state.
- i_stall  in  1  hazard-unit stall; PC holds.
- i_jump_valid  in  1  ID-stage redirect request, one cycle wide.
- i_jump_addr  in  PC_SIZE  redirect target; bits [1:0] ignored.
- i_halt  in  1  HALT opcode detected in the instruction at o_pc.
- o_pc  out  PC_SIZE  current fetch address, registered.
- o_next_pc  out  PC_SIZE  o_pc + PC_STEP, combinational; feeds the ID upper-PC bits.
- o_flush  out  1  registered one-cycle flush of the IF/ID register.
- o_halted  out  1  registered; high once HALT has been taken.

Behaviour:
- Reset: synchronous, active-high on i_reset, clock i_clock. Loads o_pc=RESET_PC, o_flush=0, o_halted=0, pend_addr=0, state=S_RUN. Reset overrides every other input, including mid-stall, mid-pending and halted.
- i_enable=0: no register changes, all inputs ignored, o_flush forced to 0 for that cycle.
- Priority per enabled cycle: reset > S_HALT > jump > stall > halt > increment.
- States: S_RUN, S_PEND, S_HALT.
- S_RUN, i_jump_valid=1 and i_stall=0:
  - o_pc <= {i_jump_addr[PC_SIZE-1:2],2'b00}; o_flush <= 1.
  - Jump wins over a simultaneous i_halt (that HALT is wrong-path).
- S_RUN, i_jump_valid=1 and i_stall=1: pend_addr <= aligned target; o_pc holds; go to S_PEND.
- S_RUN, i_stall=1 (no jump): o_pc holds; i_halt ignored while stalled.
- S_RUN, i_halt=1 (no jump, no stall): o_pc holds at the HALT address; o_halted <= 1; go to S_HALT.
- S_RUN, otherwise: o_pc <= o_pc + PC_STEP, mod 2^PC_SIZE (0xFFFF_FFFC -> 0x0000_0000, no flag).
- S_PEND, i_stall=1: o_pc holds. A new i_jump_valid overwrites pend_addr (newest wins).
- S_PEND, i_stall=0:
  - If i_jump_valid=1, load o_pc from i_jump_addr; otherwise load o_pc from pend_addr.
  - o_flush <= 1; go to S_RUN.
  - i_halt ignored in this cycle.
- S_HALT: o_pc frozen, o_halted=1, o_flush=0. All inputs except reset ignored.
- o_flush: high exactly one cycle, the same cycle o_pc first shows the redirect target; 0 in every other cycle.
- Latency: redirect request at edge N -> target on o_pc after edge N (1 cycle). With a stall, the target appears one cycle after the first edge with i_stall=0.
- o_pc[1:0] is always 2'b00.

Optional Feature:
- Macro: IF_PC_DELAY_SLOT_EN.
- Defined: MIPS branch-delay-slot semantics. o_flush is tied to 0, so the instruction already in IF/ID executes. Redirect timing is unchanged.
- Undefined: o_flush behaves as specified in Behaviour.

Decomposition:
- Shared package holds:
  - pc_state_t enum {S_RUN, S_PEND, S_HALT}, 2-bit encoding.
  - PC_SIZE_DEF and PC_STEP_DEF constants.
  - Alignment mask constant.
- One sub-module, if_pc_adder: combinational o_pc + PC_STEP. It provides o_next_pc and the increment path.
- FSM and registers stay in if_pc_redirect.

Test Plan:
- Reset, then 4 enabled cycles, no inputs -> o_pc 0x0, 0x4, 0x8, 0xC, 0x10; o_flush stays 0.
- At o_pc=0x10, pulse i_jump_valid with i_jump_addr=0x0000_0203 -> next o_pc=0x200, o_flush=1 for one cycle; then 0x204 with o_flush=0.
- i_stall=1 for 3 cycles; i_jump_valid pulses 0x400 in cycle 1 and 0x800 in cycle 2 -> o_pc holds throughout; after release o_pc=0x800 with o_flush=1.
- i_halt and i_jump_valid (0x100) in the same cycle -> o_pc=0x100, o_halted=0. Later i_halt alone at o_pc=0x108 -> o_pc frozen at 0x108, o_halted=1; jumps ignored.
- Force o_pc=0xFFFF_FFF8 through a jump, then 2 increments -> 0xFFFF_FFFC, then 0x0000_0000. i_enable=0 for 2 cycles mid-sequence -> no change. i_reset while in S_PEND -> o_pc=RESET_PC, state S_RUN.
- Build with IF_PC_DELAY_SLOT_EN defined and repeat the jump scenario -> o_pc=0x200 as before; o_flush never asserted.
